enc83_req_seq: RTL
==================

Name: enc83_req_seq

Overview:
- Sequential 8-to-3 priority encoder: the request-side counterpart of the team's 3-to-8 active-low decoder.
- Captures falling-edge events on eight active-low request lines into a sticky pending register.
- Presents the highest-priority pending index as a 3-bit code with a valid/ack handshake.
- Sits between active-low event sources (buttons, decoder-driven strobes, IRQ lines) and a consumer that services one event at a time.

Parameters:
- RESET_CODE, 3'd0, value driven on code while idle and after reset.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- req_n  input  8  active-low request lines; bit 7 has highest priority.
- en_n  input  1  active-low capture/launch enable.
- ack  input  1  consumer accepts the current code; meaningful only while valid=1.
- ovf_clr  input  1  synchronous clear of ovf.
- code  output  3  encoded index of the presented request.
- valid  output  1  code is valid.
- gs_n  output  1  active-low group select; 0 when any pending bit is set.
- ovf  output  1  sticky flag; a request edge arrived on an already-pending bit.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Internal registers: pend=8'h00, req_q=8'hFF, state=IDLE.
  - Outputs: code=RESET_CODE, valid=0, gs_n=1, ovf=0.
  - Reset mid-handshake discards all pending requests and the presented code.
- Edge detect:
  - fall[i] = req_q[i] & ~req_n[i] & ~en_n.
  - req_q <= req_n on every edge, whatever the value of en_n.
  - Falling edges that occur while en_n=1 are lost, not deferred.
- Pending register, next-state rule:
  - pend_next = (pend & ~clr_mask) | fall.
  - clr_mask is one-hot of code when valid & ack, otherwise 0.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays pending.
- Overflow:
  - ovf <= 1 when fall[i] & pend[i] & ~clr_mask[i] for any i.
  - ovf_clr=1 clears ovf. If a new overflow occurs in the same cycle, set wins.
- gs_n = ~|pend, registered; it reflects pend after the same edge.
- FSM has two states, IDLE and PRESENT.
  - IDLE: if pend != 0 and en_n=0, then code <= highest set index of pend, valid <= 1, go to PRESENT. Otherwise code=RESET_CODE and valid=0.
  - PRESENT: code and valid are held stable regardless of req_n, en_n or new higher-priority edges. On ack=1: valid <= 0, code <= RESET_CODE, the bit is cleared, go to IDLE.
  - ack while in IDLE is ignored.
- Latency and throughput:
  - A req_n falling edge sampled at edge E sets pend at E and drives valid=1 after edge E+1.
  - An ack at edge A drops valid after A. The next code can appear no earlier than after A+1, so at most one code per 2 cycles.
- Priority: fixed, index 7 > 6 > ... > 0. Within PRESENT, priority is re-evaluated only when returning to IDLE.

Optional Feature:
- Macro: ENC83_SYNC2_EN.
- Defined:
  - req_n passes through a 2-flop synchronizer (reset value 8'hFF) before edge detect.
  - Request-to-valid latency grows by 2 cycles.
  - en_n is not synchronized.
- Undefined: req_n feeds edge detect directly; the source must be synchronous to clk.

Test Plan:
- Reset, all req_n=8'hFF, en_n=0, 10 cycles → valid=0, code=0, gs_n=1, ovf=0 throughout.
- req_n[5] driven low at cycle 3 → gs_n=0 after edge 3, valid=1 with code=3'd5 after edge 4. Ack at edge 6 → valid=0, gs_n=1.
- Edges on bits 2, 6 and 0 in the same cycle → codes delivered in the order 6, 2, 0, each acked with a 1-cycle ack; gs_n returns to 1 after the final ack.
- While code=5 is presented, an edge on bit 7 arrives → code stays 5 until ack, then code=7 two cycles later.
- A second edge on pending bit 3 before its ack → ovf=1. ovf_clr → ovf=0. An edge on bit 3 in the same cycle as its ack → bit 3 re-presented, ovf stays 0.
- en_n=1 while bit 1 falls → no capture, gs_n=1. rst_n pulsed low during PRESENT → immediate valid=0, pend cleared. With ENC83_SYNC2_EN defined, latency is 4 cycles.

Source files
------------

// File: rtl/enc83_req_seq.sv
// enc83_req_seq: sequential 8-to-3 priority encoder for active-low request lines.
// Falling edges on req_n are captured into a sticky pending register; the
// highest pending index is presented on code with a valid/ack handshake.
// Optional build macro: ENC83_SYNC2_EN inserts a 2-flop synchronizer on req_n.
module enc83_req_seq #(
    parameter logic [2:0] RESET_CODE = 3'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_n,
    input  logic       en_n,
    input  logic       ack,
    input  logic       ovf_clr,
    output logic [2:0] code,
    output logic       valid,
    output logic       gs_n,
    output logic       ovf
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t     state;
    logic [7:0] req_s;       // request lines as seen by the edge detector
    logic [7:0] req_q;       // previous-cycle request lines
    logic [7:0] pend;
    logic [7:0] fall;
    logic [7:0] clr_mask;
    logic [7:0] pend_next;
    logic [2:0] top_idx;

`ifdef ENC83_SYNC2_EN
    logic [7:0] sync1;
    logic [7:0] sync2;

    // Two-flop synchronizer for asynchronous request sources; idles released (high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 8'hFF;
            sync2 <= 8'hFF;
        end else begin
            sync1 <= req_n;
            sync2 <= sync1;
        end
    end

    assign req_s = sync2;
`else
    assign req_s = req_n;
`endif

    // Falling-edge detect; edges while disabled are dropped, not deferred.
    always_comb begin
        fall = req_q & ~req_s & {8{~en_n}};
    end

    // Clear mask for the bit being acknowledged, and the next pending value.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        clr_mask = 8'h00;
        if (valid && ack) begin
            clr_mask[code] = 1'b1;
        end
        // A set and a clear on the same bit resolve in favour of the set.
        pend_next = (pend & ~clr_mask) | fall;
    end

    // Highest set index of pend: later (higher) indices override lower ones.
    always_comb begin
        top_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend[i]) begin
                top_idx = 3'(i);
            end
        end
    end

    // Edge history, pending register, group select and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= 8'hFF;
            pend  <= 8'h00;
            gs_n  <= 1'b1;
            ovf   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            req_q <= req_s;
            pend  <= pend_next;
            gs_n  <= ~|pend_next;
            if (|(fall & pend & ~clr_mask)) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // Presentation FSM: launch the top pending index, hold it until acked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            code  <= RESET_CODE;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ((pend != 8'h00) && !en_n) begin
                        code  <= top_idx;
                        valid <= 1'b1;
                        state <= PRESENT;
                    end else begin
                        code  <= RESET_CODE;
                        valid <= 1'b0;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        code  <= RESET_CODE;
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    code  <= RESET_CODE;
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
